// File: rtl/serial_adder.sv
// Handshaked multi-cycle adder/subtractor: processes WIDTH-bit operands LSB-first,
// CHUNK bits per clock, chaining chunks through a single carry flip-flop.
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             c_out,
  output logic             ovf
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = $clog2(N + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             c_out_q, c_out_d;
  logic             ovf_q, ovf_d;

  logic [CHUNK:0]   chunk_sum;
  logic [WIDTH-1:0] res_shift;
  logic             carry_into_msb;
  logic             last_chunk;

  assign chunk_sum = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]}
                   + {{CHUNK{1'b0}}, carry_q};

  // The sum bit is a^b^cin, so the carry into the chunk's top bit falls out of it.
  assign carry_into_msb = chunk_sum[CHUNK-1] ^ a_q[CHUNK-1] ^ b_q[CHUNK-1];

  assign res_shift  = WIDTH'({chunk_sum[CHUNK-1:0], res_q} >> CHUNK);
  assign last_chunk = (cnt_q == CW'(N - 1));

  always_comb begin
    // NOTE: every next-state signal gets its hold value first so no path leaves it unassigned (no latches).
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    c_out_d = c_out_q;
    ovf_d   = ovf_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b ^ {WIDTH{sub}};
          carry_d = sub | c_in;
          cnt_d   = '0;
          res_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        res_d   = res_shift;
        carry_d = chunk_sum[CHUNK];
        a_d     = a_q >> CHUNK;
        b_d     = b_q >> CHUNK;
        cnt_d   = cnt_q + CW'(1);
        if (last_chunk) begin
          c_out_d = chunk_sum[CHUNK];
          ovf_d   = carry_into_msb ^ chunk_sum[CHUNK];
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      c_out_q <= c_out_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign s         = res_q;
  assign c_out     = c_out_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: an 8-bit/1-bit-chunk and a 16-bit/4-bit-chunk
// instance share stimulus; expected results travel through a scoreboard queue.
module tb_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        sel16;
  logic        in_valid, out_ready, c_in, sub;
  logic [15:0] a, b;

  logic        iv8, iv16, or8, or16;
  logic        ir8, ov8, c8, v8;
  logic [7:0]  s8;
  logic        ir16, ov16, c16, v16;
  logic [15:0] s16;

  assign iv8  = in_valid & ~sel16;
  assign iv16 = in_valid & sel16;
  assign or8  = out_ready & ~sel16;
  assign or16 = out_ready & sel16;

  serial_adder #(.WIDTH(8), .CHUNK(1)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a[7:0]), .b(b[7:0]),
    .c_in(c_in), .sub(sub), .out_valid(ov8), .out_ready(or8), .s(s8), .c_out(c8), .ovf(v8)
  );

  serial_adder #(.WIDTH(16), .CHUNK(4)) dut16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .a(a), .b(b),
    .c_in(c_in), .sub(sub), .out_valid(ov16), .out_ready(or16), .s(s16), .c_out(c16), .ovf(v16)
  );

  logic        in_ready_m, out_valid_m, c_m, v_m;
  logic [15:0] s_m;
  assign in_ready_m  = sel16 ? ir16 : ir8;
  assign out_valid_m = sel16 ? ov16 : ov8;
  assign s_m         = sel16 ? s16 : {8'h00, s8};
  assign c_m         = sel16 ? c16 : c8;
  assign v_m         = sel16 ? v16 : v8;

  typedef struct packed {
    logic [15:0] s;
    logic        c;
    logic        v;
  } exp_t;

  typedef struct {
    logic        w16;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    exp_t        e;
  } vec_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Reference result from whole-word arithmetic.
  function automatic exp_t model(input logic w16, input logic [15:0] ta, input logic [15:0] tb,
                                 input logic tcin, input logic tsub);
    logic [15:0] mask, aa, bb;
    logic [16:0] full;
    logic        cin, ma, mb, ms;
    exp_t        r;
    mask = w16 ? 16'hFFFF : 16'h00FF;
    aa   = ta & mask;
    bb   = (tsub ? ~tb : tb) & mask;
    cin  = tsub ? 1'b1 : tcin;
    full = {1'b0, aa} + {1'b0, bb} + {16'h0, cin};
    if (w16) begin
      r.s = full[15:0]; r.c = full[16]; ma = aa[15]; mb = bb[15]; ms = full[15];
    end else begin
      r.s = {8'h00, full[7:0]}; r.c = full[8]; ma = aa[7]; mb = bb[7]; ms = full[7];
    end
    r.v = (ma == mb) && (ms != ma);
    return r;
  endfunction

  task automatic wait_ready();
    int k = 0;
    while (!in_ready_m && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    check("in_ready_before_accept", in_ready_m, 1'b1);
  endtask

  task automatic wait_out_valid(output int cycles);
    cycles = 0;
    while (!out_valid_m && cycles < 40) begin
      @(posedge clk); #1;
      cycles++;
    end
  endtask

  task automatic compare_result(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      check({tag, "_scoreboard_nonempty"}, 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      check({tag, "_s"}, s_m, e.s);
      check({tag, "_c_out"}, c_m, e.c);
      check({tag, "_ovf"}, v_m, e.v);
    end
  endtask

  task automatic run_op(input string tag, input logic w16, input logic [15:0] ta,
                        input logic [15:0] tb, input logic tcin, input logic tsub,
                        input exp_t e, input int lat);
    int cyc;
    sel16 = w16;
    #1;
    wait_ready();
    a = ta; b = tb; c_in = tcin; sub = tsub; in_valid = 1'b1;
    sb_q.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
    // Scramble inputs after accept; the result must not depend on them.
    a = ~ta; b = ~tb; c_in = ~tcin; sub = ~tsub;
    check({tag, "_busy"}, in_ready_m, 1'b0);
    wait_out_valid(cyc);
    check({tag, "_latency"}, cyc, lat);
    compare_result(tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_out_valid_drop"}, out_valid_m, 1'b0);
    check({tag, "_in_ready_back"}, in_ready_m, 1'b1);
  endtask

  vec_t vecs[8];

  initial begin
    int   cyc;
    exp_t e;
    logic [15:0] ra, rb;
    logic rc, rs;

    vecs[0] = '{1'b0, 16'h005A, 16'h0033, 1'b0, 1'b0, '{16'h008D, 1'b0, 1'b1}};
    vecs[1] = '{1'b0, 16'h00FF, 16'h0001, 1'b1, 1'b0, '{16'h0001, 1'b1, 1'b0}};
    vecs[2] = '{1'b0, 16'h0010, 16'h0020, 1'b1, 1'b1, '{16'h00F0, 1'b0, 1'b0}};
    vecs[3] = '{1'b0, 16'h0080, 16'h0001, 1'b0, 1'b1, '{16'h007F, 1'b1, 1'b1}};
    vecs[4] = '{1'b0, 16'h007F, 16'h0001, 1'b0, 1'b0, '{16'h0080, 1'b0, 1'b1}};
    vecs[5] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, '{16'h0000, 1'b1, 1'b0}};
    vecs[6] = '{1'b1, 16'h1234, 16'hEDCC, 1'b0, 1'b0, '{16'h0000, 1'b1, 1'b0}};
    vecs[7] = '{1'b1, 16'h8000, 16'h8000, 1'b0, 1'b0, '{16'h0000, 1'b1, 1'b1}};

    rst = 1'b1; sel16 = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; c_in = 1'b0; sub = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_in_ready", in_ready_m, 1'b1);
    check("reset_out_valid", out_valid_m, 1'b0);
    check("reset_s", s_m, 16'h0000);
    check("reset_c_out", c_m, 1'b0);
    check("reset_ovf", v_m, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++)
      run_op($sformatf("vec%0d", i), vecs[i].w16, vecs[i].a, vecs[i].b, vecs[i].cin,
             vecs[i].sub, vecs[i].e, vecs[i].w16 ? 4 : 8);

    for (int i = 0; i < 10; i++) begin
      ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom); rs = 1'($urandom);
      e  = model(i[0], ra, rb, rc, rs);
      run_op($sformatf("rand%0d", i), i[0], ra, rb, rc, rs, e, i[0] ? 4 : 8);
    end

    // Backpressure: in_valid held high through RUN and DONE, out_ready low for 5 cycles.
    sel16 = 1'b0;
    #1;
    wait_ready();
    a = 16'h005A; b = 16'h0033; c_in = 1'b0; sub = 1'b0; in_valid = 1'b1;
    sb_q.push_back('{16'h008D, 1'b0, 1'b1});
    @(posedge clk); #1;
    wait_out_valid(cyc);
    check("bp_latency", cyc, 8);
    compare_result("bp");
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check($sformatf("bp_hold%0d_out_valid", i), out_valid_m, 1'b1);
      check($sformatf("bp_hold%0d_in_ready", i), in_ready_m, 1'b0);
      check($sformatf("bp_hold%0d_s", i), s_m, 16'h008D);
      check($sformatf("bp_hold%0d_flags", i), {c_m, v_m}, 2'b01);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    check("bp_release_out_valid", out_valid_m, 1'b0);
    check("bp_release_in_ready", in_ready_m, 1'b1);
    @(posedge clk); #1;
    check("bp_idle_stays", in_ready_m, 1'b1);

    // Reset during the third RUN cycle discards the operation.
    a = 16'h005A; b = 16'h0033; c_in = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mid_run_busy", in_ready_m, 1'b0);
    rst = 1'b1;
    #1;
    check("rst_out_valid", out_valid_m, 1'b0);
    check("rst_in_ready", in_ready_m, 1'b1);
    check("rst_s", s_m, 16'h0000);
    check("rst_flags", {c_m, v_m}, 2'b00);
    @(posedge clk); #1;
    rst = 1'b0;
    run_op("after_rst", 1'b0, 16'h0001, 16'h0002, 1'b0, 1'b0, '{16'h0003, 1'b0, 1'b0}, 8);

    check("scoreboard_drained", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
